// File: rtl/pipelined_normalizer.sv
// Two-stage pipelined leading-one normaliser with valid/ready flow control on both sides.
// Define NORMALIZER_STICKY_EN to add the out_sticky port (OR of the truncated low bits).
module pipelined_normalizer #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned OUT_WIDTH = 24,
  localparam int unsigned POS_W    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_value,
  output logic [POS_W-1:0]     out_position,
  output logic [POS_W-1:0]     out_shift,
  output logic                 out_zero
`ifdef NORMALIZER_STICKY_EN
  ,
  output logic                 out_sticky
`endif
);

  // Low WIDTH-OUT_WIDTH ones; all-zero when nothing is truncated.
  localparam logic [WIDTH-1:0] DropMask = {WIDTH{1'b1}} >> OUT_WIDTH;

  logic s1_adv, s2_adv;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_value_q;
  logic [POS_W-1:0] s1_pos_q;
  logic             s1_zero_q;

  logic                 s2_valid_q;
  logic [OUT_WIDTH-1:0] s2_value_q;
  logic [POS_W-1:0]     s2_pos_q;
  logic [POS_W-1:0]     s2_shift_q;
  logic                 s2_zero_q;

  logic [POS_W-1:0]     lead_pos;
  logic                 lead_zero;
  logic [POS_W-1:0]     shift_d;
  logic [WIDTH-1:0]     shifted;
  logic [OUT_WIDTH-1:0] value_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Ascending scan so the highest set bit wins; zero input leaves position 0.
  always_comb begin
    lead_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_value[i]) lead_pos = POS_W'(i);
    end
  end

  assign lead_zero = ~|in_value;

  always_comb begin
    shift_d = s1_zero_q ? '0 : POS_W'(WIDTH - 1) - s1_pos_q;
    shifted = s1_value_q << shift_d;
    value_d = OUT_WIDTH'(shifted >> (WIDTH - OUT_WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= '0;
      s1_pos_q   <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_value_q <= in_value;
        s1_pos_q   <= lead_pos;
        s1_zero_q  <= lead_zero;
      end
    end
  end

  // A bubble from S1 only clears the valid bit; the data fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_value_q <= '0;
      s2_pos_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_value_q <= value_d;
        s2_pos_q   <= s1_pos_q;
        s2_shift_q <= shift_d;
        s2_zero_q  <= s1_zero_q;
      end
    end
  end

`ifdef NORMALIZER_STICKY_EN
  logic s2_sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sticky_q <= 1'b0;
    end else if (s2_adv && s1_valid_q) begin
      s2_sticky_q <= |(shifted & DropMask);
    end
  end

  assign out_sticky = s2_sticky_q;
`endif

  assign out_valid    = s2_valid_q;
  assign out_value    = s2_value_q;
  assign out_position = s2_pos_q;
  assign out_shift    = s2_shift_q;
  assign out_zero     = s2_zero_q;

endmodule

// File: tb/tb_pipelined_normalizer.sv
// Bench for pipelined_normalizer: directed vectors on an 8->5 instance, randomised flow control
// on a 24->24 instance. Sticky checks apply when NORMALIZER_STICKY_EN is defined.
module tb_pipelined_normalizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_sticky;
  logic [7:0] a_in_value;
  logic [4:0] a_out_value;
  logic [2:0] a_out_position, a_out_shift;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_sticky;
  logic [23:0] b_in_value, b_out_value;
  logic [4:0]  b_out_position, b_out_shift;

  pipelined_normalizer #(
    .WIDTH     (8),
    .OUT_WIDTH (5)
  ) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (a_in_valid),
    .in_ready     (a_in_ready),
    .in_value     (a_in_value),
    .out_valid    (a_out_valid),
    .out_ready    (a_out_ready),
    .out_value    (a_out_value),
    .out_position (a_out_position),
`ifdef NORMALIZER_STICKY_EN
    .out_sticky   (a_out_sticky),
`endif
    .out_shift    (a_out_shift),
    .out_zero     (a_out_zero)
  );

  pipelined_normalizer #(
    .WIDTH     (24),
    .OUT_WIDTH (24)
  ) u_dut24 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_value     (b_in_value),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_value    (b_out_value),
    .out_position (b_out_position),
`ifdef NORMALIZER_STICKY_EN
    .out_sticky   (b_out_sticky),
`endif
    .out_shift    (b_out_shift),
    .out_zero     (b_out_zero)
  );

`ifndef NORMALIZER_STICKY_EN
  assign a_out_sticky = 1'b0;
  assign b_out_sticky = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] in;
    logic [2:0] pos;
    logic [2:0] shift;
    logic [4:0] value;
    logic       zero;
    logic       sticky;
  } vec_t;

  vec_t vecs [0:6];
  logic [7:0] stall_in [0:2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t e);
    check({tag, ".valid"}, a_out_valid, 1);
    check({tag, ".pos"}, a_out_position, e.pos);
    check({tag, ".shift"}, a_out_shift, e.shift);
    check({tag, ".value"}, a_out_value, e.value);
    check({tag, ".zero"}, a_out_zero, e.zero);
`ifdef NORMALIZER_STICKY_EN
    check({tag, ".sticky"}, a_out_sticky, e.sticky);
`endif
  endtask

  function automatic logic [23:0] rand24();
    logic [31:0] r;
    r = $urandom();
    return r[23:0] >> $urandom_range(0, 24);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] q [$];
    logic [23:0] v;
    int idx, got, sent, cyc, p, sh;

    vecs[0] = '{in: 8'h13, pos: 3'd4, shift: 3'd3, value: 5'b10011, zero: 1'b0, sticky: 1'b0};
    vecs[1] = '{in: 8'h01, pos: 3'd0, shift: 3'd7, value: 5'b10000, zero: 1'b0, sticky: 1'b0};
    vecs[2] = '{in: 8'hFF, pos: 3'd7, shift: 3'd0, value: 5'b11111, zero: 1'b0, sticky: 1'b1};
    vecs[3] = '{in: 8'h00, pos: 3'd0, shift: 3'd0, value: 5'b00000, zero: 1'b1, sticky: 1'b0};
    vecs[4] = '{in: 8'h03, pos: 3'd1, shift: 3'd6, value: 5'b11000, zero: 1'b0, sticky: 1'b0};
    vecs[5] = '{in: 8'h07, pos: 3'd2, shift: 3'd5, value: 5'b11100, zero: 1'b0, sticky: 1'b0};
    vecs[6] = '{in: 8'h2D, pos: 3'd5, shift: 3'd2, value: 5'b10110, zero: 1'b0, sticky: 1'b1};
    stall_in[0] = 8'h13;
    stall_in[1] = 8'h2D;
    stall_in[2] = 8'h07;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_value  = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_value  = '0;
    b_out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", a_out_valid, 0);
    check("rst.value", a_out_value, 0);
    check("rst.pos", a_out_position, 0);
    check("rst.shift", a_out_shift, 0);
    check("rst.zero", a_out_zero, 0);
    check("rst.sticky", a_out_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", a_in_ready, 1);

    // Back-to-back directed vectors, output two cycles after each input
    a_out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k >= 2) check_out($sformatf("vec%0d", k - 2), vecs[k-2]);
      check("stream.in_ready", a_in_ready, 1);
      if (k < 7) begin
        a_in_valid = 1'b1;
        a_in_value = vecs[k].in;
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream.drained", a_out_valid, 0);

    // Backpressure: two accepted, then held stable
    a_out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      a_in_valid = 1'b1;
      a_in_value = stall_in[idx];
      if (a_in_ready && idx < 2) idx++;
      else if (a_in_ready) idx = 3;
      if (c >= 2) begin
        check("stall.in_ready", a_in_ready, 0);
        check_out("stall.hold", vecs[0]);
      end
      @(negedge clk);
    end
    check("stall.accepted", idx, 2);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check_out("drain0", vecs[0]);
    @(negedge clk);
    check_out("drain1", vecs[6]);
    @(negedge clk);
    check("drain.empty", a_out_valid, 0);

    // Reset with both stages full
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_value  = 8'hFF;
    @(negedge clk);
    a_in_value  = 8'h00;
    @(negedge clk);
    a_in_valid  = 1'b0;
    check_out("prerst", vecs[2]);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.valid", a_out_valid, 0);
    check("midrst.value", a_out_value, 0);
    check("midrst.pos", a_out_position, 0);
    check("midrst.shift", a_out_shift, 0);
    check("midrst.sticky", a_out_sticky, 0);
    @(negedge clk);
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst.valid", a_out_valid, 0);
    end

    // Random flow control on the full-width instance
    got  = 0;
    sent = 0;
    cyc  = 0;
    while (got < 400 && cyc < 5000) begin
      b_in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
      b_in_value  = rand24();
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_in_valid && b_in_ready) begin
        q.push_back(b_in_value);
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        if (q.size() == 0) begin
          check("rnd.spurious", b_out_valid, 0);
        end else begin
          v = q.pop_front();
          p = 0;
          for (int i = 23; i >= 0; i--) begin
            if (v[i] && p == 0 && (v >> i) == 24'd1) p = i;
          end
          sh = (v == 0) ? 0 : 23 - p;
          check("rnd.value", b_out_value, v << sh);
          check("rnd.pos", b_out_position, p);
          check("rnd.shift", b_out_shift, sh);
          check("rnd.zero", b_out_zero, (v == 0));
`ifdef NORMALIZER_STICKY_EN
          check("rnd.sticky", b_out_sticky, 0);
`endif
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rnd.count", got, 400);
    b_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
